fpga_cfg_loader: RTL

Configuration controller for the fpga fabric model. On a start pulse it fetches CFG_WIDTH bitstream columns from a word memory, one column at a time. Each column is presented on cdata with a one-cycle shift strobe into the fabric's configuration chain. While loading, it also gates the CPU's PCPI requests so that the fabric is never exercised half-configured.

---
 rtl/fpga_cfg_pkg.sv | 25 ++
 rtl/fpga_cfg_loader_if.sv | 37 +++
 rtl/fpga_cfg_pcpi_gate.sv | 21 ++
 rtl/fpga_cfg_loader.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
//==============================================================================
// Module      : fpga_cfg_pkg
// Description : Shared FSM encoding and default sizes for the fabric config loader.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package fpga_cfg_pkg;

    localparam int c_CFG_HEIGHT_DEF = 32;
    localparam int c_CFG_WIDTH_DEF  = 64;
    localparam int c_ADDR_W_DEF     = 16;
    localparam int CFG_CNT_W        = $clog2(c_CFG_WIDTH_DEF);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_FIN   = 3'd4
    } cfg_state_t;

endpackage

`default_nettype wire

// File: rtl/fpga_cfg_loader_if.sv
//==============================================================================
// Module      : fpga_cfg_loader_if
// Description : Single-outstanding word-read bus between the loader and memory.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface fpga_cfg_loader_if
    import fpga_cfg_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEF,
    parameter int DATA_W = c_CFG_HEIGHT_DEF
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/fpga_cfg_pcpi_gate.sv
//==============================================================================
// Module      : fpga_cfg_pcpi_gate
// Description : Blocks CPU PCPI traffic to the fabric while it is not fully configured.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fpga_cfg_pcpi_gate (
    input  logic cpu_pcpi_valid,
    input  logic cfg_valid,
    input  logic busy,
    output logic fab_pcpi_valid,
    output logic cpu_pcpi_wait
);

    assign fab_pcpi_valid = cpu_pcpi_valid & cfg_valid & ~busy;
    assign cpu_pcpi_wait  = cpu_pcpi_valid & busy;

endmodule

`default_nettype wire

// File: rtl/fpga_cfg_loader.sv
//==============================================================================
// Module      : fpga_cfg_loader
// Description : Fetches CFG_WIDTH columns from memory and shifts them into the fabric.
//               Optional XOR checksum word after the last column: CFG_LOADER_CRC_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CFG_HEIGHT = c_CFG_HEIGHT_DEF,
    parameter int CFG_WIDTH  = c_CFG_WIDTH_DEF,
    parameter int ADDR_W     = c_ADDR_W_DEF
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    fpga_cfg_loader_if.master     mem,
    output logic                  shift,
    output logic [CFG_HEIGHT-1:0] cdata,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_valid,
    output logic                  err,
    input  logic                  cpu_pcpi_valid,
    output logic                  fab_pcpi_valid,
    output logic                  cpu_pcpi_wait
);

    localparam int c_CNT_W = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;

    cfg_state_t            r_state;
    cfg_state_t            w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]     r_addr;
    logic [CFG_HEIGHT-1:0] r_cdata;
    logic                  r_cfg_valid;
    logic                  w_req;
    logic                  w_shift;
    logic                  w_done;
    logic                  w_busy;
    logic                  w_last;
    logic                  w_chk;
    logic                  w_err;
    logic                  w_inc_addr;

    assign w_last = (r_cnt == c_CNT_W'(CFG_WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        w_busy      = 1'b1;
        w_inc_addr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                w_req = 1'b1;
                if (mem.mem_gnt) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // the checksum word is consumed here and never reaches the fabric
                if (mem.mem_rvalid) w_state_nxt = w_chk ? ST_FIN : ST_SHIFT;
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (!w_last) begin
                    w_inc_addr  = 1'b1;
                    w_state_nxt = ST_REQ;
                end else begin
`ifdef CFG_LOADER_CRC_EN
                    w_inc_addr  = 1'b1;
                    w_state_nxt = ST_REQ;
`else
                    w_state_nxt = ST_FIN;
`endif
                end
            end
            ST_FIN: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr      <= '0;
            r_cnt       <= '0;
            r_cdata     <= '0;
            r_cfg_valid <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_addr      <= base_addr;
                r_cnt       <= '0;
                r_cfg_valid <= 1'b0;
            end
            if (r_state == ST_WAIT && mem.mem_rvalid && !w_chk)
                r_cdata <= mem.mem_rdata;
            if (w_inc_addr)
                r_addr <= r_addr + ADDR_W'(1);
            if (r_state == ST_SHIFT && !w_last)
                r_cnt <= r_cnt + c_CNT_W'(1);
            if (r_state == ST_FIN)
                r_cfg_valid <= ~w_err;
        end
    end

`ifdef CFG_LOADER_CRC_EN
    logic                  r_chk;
    logic [CFG_HEIGHT-1:0] r_acc;
    logic                  r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_chk <= 1'b0;
            r_acc <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_chk <= 1'b0;
                        r_acc <= '0;
                        r_err <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (mem.mem_rvalid && r_chk) r_err <= (mem.mem_rdata != r_acc);
                end
                ST_SHIFT: begin
                    r_acc <= r_acc ^ r_cdata;
                    if (w_last) r_chk <= 1'b1;
                end
                ST_FIN:  r_chk <= 1'b0;
                default: r_chk <= r_chk;
            endcase
        end
    end

    assign w_chk = r_chk;
    assign w_err = r_err;
`else
    assign w_chk = 1'b0;
    assign w_err = 1'b0;
`endif

    assign mem.mem_req  = w_req;
    assign mem.mem_addr = r_addr;
    assign shift        = w_shift;
    assign cdata        = r_cdata;
    assign busy         = w_busy;
    assign done         = w_done;
    assign cfg_valid    = r_cfg_valid;
    assign err          = w_err;

    fpga_cfg_pcpi_gate u_pcpi_gate (
        .cpu_pcpi_valid (cpu_pcpi_valid),
        .cfg_valid      (r_cfg_valid),
        .busy           (w_busy),
        .fab_pcpi_valid (fab_pcpi_valid),
        .cpu_pcpi_wait  (cpu_pcpi_wait)
    );

endmodule

`default_nettype wire
